// File: rtl/man_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : man_drive_ctrl
// Purpose  : Manual-drive pedal FSM with saturating speed level, coasting
//            decay, multi-step braking and a standstill-only direction latch.
// Revision : 1.0 - initial release
// ============================================================================
module man_drive_ctrl #(
    parameter int SPEED_W     = 4,
    parameter int MAX_SPEED   = 15,
    parameter int TICK_W      = 8,
    parameter int ACCEL_TICKS = 4,
    parameter int COAST_TICKS = 8,
    parameter int BRAKE_STEP  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               reverse,
    input  logic               brake,
    input  logic               clutch,
    input  logic               throttle,
    input  logic               left,
    input  logic               right,
    output logic               stalled,
    output logic               move_forward,
    output logic               move_backward,
    output logic               turn_left,
    output logic               turn_right,
    output logic [1:0]         out_state,
    output logic [SPEED_W-1:0] speed
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        START  = 2'b01,
        MOVING = 2'b10,
        STALL  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        M_NONE  = 2'b00,
        M_ACCEL = 2'b01,
        M_COAST = 2'b10,
        M_BRAKE = 2'b11
    } mode_t;

    localparam logic [SPEED_W-1:0] c_max_speed  = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] c_brake_step = SPEED_W'(BRAKE_STEP);
    localparam logic [TICK_W-1:0]  c_accel_last = TICK_W'(ACCEL_TICKS - 1);
    localparam logic [TICK_W-1:0]  c_coast_last = TICK_W'(COAST_TICKS - 1);

    state_t               r_state;
    mode_t                r_mode;
    logic [SPEED_W-1:0]   r_speed;
    logic [TICK_W-1:0]    r_tick;
    logic                 r_dir;

    logic [2:0]           w_pedals;
    logic                 w_active;
    logic                 w_dir_conflict;
    mode_t                w_mode;
    logic [TICK_W-1:0]    w_tick_base;
    state_t               w_next_state;
    logic [SPEED_W-1:0]   w_next_speed;
    logic [TICK_W-1:0]    w_next_tick;

    assign w_pedals       = {brake, throttle, clutch};
    assign w_active       = (r_state == START) || (r_state == MOVING);
    assign w_dir_conflict = (reverse != r_dir) && (r_speed != '0);
    // A new speed mode restarts its cadence from zero on this very cycle.
    assign w_tick_base    = (w_mode != r_mode) ? '0 : r_tick;

    always_comb begin
        w_mode = M_NONE;
        if (w_active) begin
            if (brake)
                w_mode = M_BRAKE;
            else if ((r_state == MOVING) && (w_pedals == 3'b010))
                w_mode = M_ACCEL;
            else
                w_mode = M_COAST;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_speed = r_speed;
        w_next_tick  = w_tick_base + TICK_W'(1);
        case (w_mode)
            M_BRAKE: begin
                w_next_tick  = '0;
                w_next_speed = (r_speed > c_brake_step) ? (r_speed - c_brake_step) : '0;
                if (r_speed <= c_brake_step)
                    w_next_state = IDLE;
            end
            M_ACCEL: begin
                if (w_tick_base == c_accel_last) begin
                    w_next_tick = '0;
                    if (r_speed < c_max_speed)
                        w_next_speed = r_speed + SPEED_W'(1);
                end
            end
            M_COAST: begin
                w_next_state = (w_pedals == 3'b010) ? MOVING : START;
                if (w_tick_base == c_coast_last) begin
                    w_next_tick = '0;
                    if (r_speed != '0)
                        w_next_speed = r_speed - SPEED_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mode  <= M_NONE;
            r_speed <= '0;
            r_tick  <= '0;
            r_dir   <= 1'b0;
        end else if (!enable) begin
            r_state <= IDLE;
            r_mode  <= M_NONE;
            r_speed <= '0;
            r_tick  <= '0;
            r_dir   <= reverse;
        end else begin
            case (r_state)
                IDLE: begin
                    r_dir  <= reverse;
                    r_mode <= M_NONE;
                    r_tick <= '0;
                    if (w_pedals == 3'b010)
                        r_state <= STALL;
                    else if (w_pedals == 3'b011)
                        r_state <= START;
                end
                STALL: begin
                    r_mode  <= M_NONE;
                    r_speed <= '0;
                    r_tick  <= '0;
                end
                default: begin
                    // Gear flipped while rolling: the engine stalls.
                    if (w_dir_conflict) begin
                        r_state <= STALL;
                        r_mode  <= M_NONE;
                        r_speed <= '0;
                        r_tick  <= '0;
                    end else begin
                        if (r_speed == '0)
                            r_dir <= reverse;
                        r_mode  <= w_mode;
                        r_state <= w_next_state;
                        r_speed <= w_next_speed;
                        r_tick  <= (w_next_state != r_state) ? '0 : w_next_tick;
                    end
                end
            endcase
        end
    end

    assign out_state     = r_state;
    assign speed         = r_speed;
    assign stalled       = (r_state == STALL);
    assign move_forward  = w_active & (r_speed != '0) & ~r_dir;
    assign move_backward = w_active & (r_speed != '0) & r_dir;
    assign turn_left     = w_active & left & ~right;
    assign turn_right    = w_active & right & ~left;

endmodule
`default_nettype wire

// File: tb/tb_man_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_man_drive_ctrl
// Purpose  : Directed scenarios plus randomized pedal traffic for
//            man_drive_ctrl, checked against a streak-counting drive model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_man_drive_ctrl;

    localparam int SPEED_W     = 4;
    localparam int MAX_SPEED   = 15;
    localparam int ACCEL_TICKS = 4;
    localparam int COAST_TICKS = 8;
    localparam int BRAKE_STEP  = 2;

    localparam int ST_IDLE  = 0;
    localparam int ST_START = 1;
    localparam int ST_MOV   = 2;
    localparam int ST_STALL = 3;

    localparam int MD_NONE  = 0;
    localparam int MD_ACCEL = 1;
    localparam int MD_COAST = 2;
    localparam int MD_BRAKE = 3;

    logic clk = 1'b0;
    logic rst_n, enable, reverse, brake, clutch, throttle, left, right;
    logic stalled, move_forward, move_backward, turn_left, turn_right;
    logic [1:0]         out_state;
    logic [SPEED_W-1:0] speed;
    logic [10:0]        dut_vec;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: speed changes after a run of N identical-mode cycles.
    int m_state, m_speed, m_streak, m_mode;
    bit m_dir;

    always #5 clk = ~clk;

    man_drive_ctrl #(
        .SPEED_W(SPEED_W), .MAX_SPEED(MAX_SPEED), .TICK_W(8),
        .ACCEL_TICKS(ACCEL_TICKS), .COAST_TICKS(COAST_TICKS), .BRAKE_STEP(BRAKE_STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .reverse(reverse),
        .brake(brake), .clutch(clutch), .throttle(throttle),
        .left(left), .right(right), .stalled(stalled),
        .move_forward(move_forward), .move_backward(move_backward),
        .turn_left(turn_left), .turn_right(turn_right),
        .out_state(out_state), .speed(speed)
    );

    assign dut_vec = {stalled, move_forward, move_backward, turn_left, turn_right, out_state, speed};

    task automatic model_reset();
        m_state = ST_IDLE; m_speed = 0; m_streak = 0; m_mode = MD_NONE; m_dir = 1'b0;
    endtask

    task automatic model_step();
        int p, nstate, mode;
        p = {brake, throttle, clutch};
        if (!enable) begin
            m_state = ST_IDLE; m_speed = 0; m_streak = 0; m_mode = MD_NONE; m_dir = reverse;
        end else if (m_state == ST_IDLE) begin
            m_dir = reverse; m_mode = MD_NONE; m_streak = 0;
            if (p == 2) m_state = ST_STALL;
            else if (p == 3) m_state = ST_START;
        end else if (m_state == ST_STALL) begin
            m_speed = 0; m_streak = 0; m_mode = MD_NONE;
        end else if (reverse != m_dir && m_speed != 0) begin
            m_state = ST_STALL; m_speed = 0; m_streak = 0; m_mode = MD_NONE;
        end else begin
            if (m_speed == 0) m_dir = reverse;
            nstate = m_state;
            if (brake) mode = MD_BRAKE;
            else if (m_state == ST_MOV && p == 2) mode = MD_ACCEL;
            else mode = MD_COAST;
            if (mode != m_mode) m_streak = 0;
            if (mode == MD_BRAKE) begin
                if (m_speed <= BRAKE_STEP) nstate = ST_IDLE;
                m_speed  = (m_speed > BRAKE_STEP) ? m_speed - BRAKE_STEP : 0;
                m_streak = 0;
            end else if (mode == MD_ACCEL) begin
                m_streak++;
                if (m_streak == ACCEL_TICKS) begin
                    m_streak = 0;
                    if (m_speed < MAX_SPEED) m_speed++;
                end
            end else begin
                nstate = (p == 2) ? ST_MOV : ST_START;
                m_streak++;
                if (m_streak == COAST_TICKS) begin
                    m_streak = 0;
                    if (m_speed > 0) m_speed--;
                end
            end
            if (nstate != m_state) m_streak = 0;
            m_state = nstate;
            m_mode  = mode;
        end
    endtask

    function automatic logic [10:0] exp_vec();
        bit act;
        act = (m_state == ST_START) || (m_state == ST_MOV);
        return {m_state == ST_STALL, act && m_speed != 0 && !m_dir, act && m_speed != 0 && m_dir,
                act && left && !right, act && right && !left, 2'(m_state), 4'(m_speed)};
    endfunction

    task automatic set_p(input logic [2:0] p);
        {brake, throttle, clutch} = p;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; reverse = 1'b0; set_p(3'b011); left = 1'b1; right = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (dut_vec !== 11'd0) $display("FAIL reset_outputs got=%h exp=000", dut_vec);
        else n_pass++;
        rst_n = 1'b1; left = 1'b0; set_p(3'b000);
        @(negedge clk);
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_release got=%h exp=%h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_accel();
        set_p(3'b011); step();
        n_checks++;
        if (out_state !== 2'b01) $display("FAIL accel_start got=%0d exp=1", out_state);
        else n_pass++;
        set_p(3'b010); step();
        n_checks++;
        if (out_state !== 2'b10) $display("FAIL accel_moving got=%0d exp=2", out_state);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL accel_cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (speed !== 4'd3 || move_forward !== 1'b1 || out_state !== 2'b10)
            $display("FAIL accel_12cyc got=spd%0d fwd%0d st%0d exp=spd3 fwd1 st2", speed, move_forward, out_state);
        else n_pass++;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 80; i++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL sat_cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (speed !== 4'd15) $display("FAIL sat_ceiling got=%0d exp=15", speed);
        else n_pass++;
    endtask

    task automatic test_coast();
        set_p(3'b000); step();
        n_checks++;
        if (out_state !== 2'b01 || speed !== 4'd15) $display("FAIL coast_enter got=st%0d spd%0d exp=st1 spd15", out_state, speed);
        else n_pass++;
        for (int k = 1; k <= 2; k++) begin
            repeat (COAST_TICKS) step();
            n_checks++;
            if (speed !== 4'(15 - k) || move_forward !== 1'b1)
                $display("FAIL coast_decay%0d got=spd%0d fwd%0d exp=spd%0d fwd1", k, speed, move_forward, 15 - k);
            else n_pass++;
        end
    endtask

    task automatic test_brake();
        int exp_spd[4] = '{5, 3, 1, 0};
        int exp_st[4]  = '{ST_MOV, ST_MOV, ST_MOV, ST_IDLE};
        set_p(3'b010); step();
        set_p(3'b100); repeat (3) step();
        n_checks++;
        if (speed !== 4'd7 || out_state !== 2'b10) $display("FAIL brake_setup got=spd%0d st%0d exp=spd7 st2", speed, out_state);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (speed !== 4'(exp_spd[i]) || out_state !== 2'(exp_st[i]) || dut_vec !== exp_vec())
                $display("FAIL brake_edge%0d got=spd%0d st%0d exp=spd%0d st%0d", i, speed, out_state, exp_spd[i], exp_st[i]);
            else n_pass++;
        end
        n_checks++;
        if (move_forward !== 1'b0) $display("FAIL brake_stop_fwd got=%0d exp=0", move_forward);
        else n_pass++;
    endtask

    task automatic test_reverse_stall();
        bit seen;
        set_p(3'b011); step();
        set_p(3'b010); repeat (13) step();
        n_checks++;
        if (speed !== 4'd3) $display("FAIL rev_setup got=%0d exp=3", speed);
        else n_pass++;
        reverse = 1'b1; step();
        n_checks++;
        if (stalled !== 1'b1 || speed !== 4'd0 || out_state !== 2'b11)
            $display("FAIL rev_stall got=stl%0d spd%0d st%0d exp=stl1 spd0 st3", stalled, speed, out_state);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            set_p(3'($urandom_range(0, 7))); step();
            n_checks++;
            if (out_state !== 2'b11 || dut_vec !== exp_vec()) $display("FAIL stall_hold%0d got=%h exp=%h", i, dut_vec, exp_vec());
            else n_pass++;
        end
        enable = 1'b0; step(); enable = 1'b1;
        n_checks++;
        if (out_state !== 2'b00) $display("FAIL stall_exit got=%0d exp=0", out_state);
        else n_pass++;
        set_p(3'b011); step();
        set_p(3'b010);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            n_checks++;
            if (stalled !== 1'b0 || dut_vec !== exp_vec()) $display("FAIL rev_drive%0d got=%h exp=%h", i, dut_vec, exp_vec());
            else n_pass++;
            if (speed == 4'd1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || move_backward !== 1'b1 || move_forward !== 1'b0)
            $display("FAIL rev_backward got=seen%0d bwd%0d fwd%0d exp=seen1 bwd1 fwd0", seen, move_backward, move_forward);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        bit hit;
        hit = 1'b0;
        left = 1'b1;
        for (int i = 0; i < 60 && !hit; i++) begin
            step();
            if (speed == 4'd9) hit = 1'b1;
        end
        n_checks++;
        if (!hit || out_state !== 2'b10 || turn_left !== 1'b1) $display("FAIL arst_setup got=spd%0d st%0d exp=spd9 st2", speed, out_state);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (dut_vec !== 11'd0) $display("FAIL arst_immediate got=%h exp=000", dut_vec);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; left = 1'b0; reverse = 1'b0; set_p(3'b000);
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 1500; i++) begin
            enable = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 19) == 0) reverse = ~reverse;
            r = $urandom_range(0, 9);
            if (r < 5) set_p(3'b010);
            else if (r == 5) set_p(3'b011);
            else if (r < 8) set_p({2'b00, 1'($urandom_range(0, 1))});
            else if (r == 8) set_p(3'b100);
            else set_p(3'($urandom_range(0, 7)));
            left  = 1'($urandom_range(0, 1));
            right = 1'($urandom_range(0, 1));
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL random_cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_accel();
        test_saturate();
        test_coast();
        test_brake();
        test_reverse_stall();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
